// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings for the DataMem access unit
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] MEM_EN  = 2'b01;
  localparam logic [1:0] MEM_OFF = 2'b00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/lane_align.sv
// rtl/lane_align.sv - little-endian lane extract/sign-extend for loads and lane merge for stores
module lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        isSigned,
  input  logic [31:0] data,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel    = word[{addrLo, 3'b000} +: 8];
    halfSel    = addrLo[1] ? word[31:16] : word[15:0];
    loadData   = word;
    mergedWord = data;
    case (size)
      SIZE_BYTE: begin
        loadData   = {{24{isSigned & byteSel[7]}}, byteSel};
        mergedWord = word;
        mergedWord[{addrLo, 3'b000} +: 8] = data[7:0];
      end
      SIZE_HALF: begin
        loadData   = {{16{isSigned & halfSel[15]}}, halfSel};
        mergedWord = addrLo[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
      end
      default: begin
        loadData   = word;
        mergedWord = data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for DataMem with sub-word RMW; MISALIGN_TRAP_EN enables misalignment trapping
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [31:0]       RespData,
  output logic              RespError,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       WriteData,
  output logic [1:0]        MemWrite,
  output logic [1:0]        MemRead,
  input  logic [31:0]       ReadData
);

  state_t            state, stateNext;
  logic              reqWriteQ, signedQ, respErrorQ;
  logic [1:0]        sizeQ, addrLoQ;
  logic [2:0]        cntQ;
  logic [31:0]       dataQ, readWordQ, writeDataQ, respDataQ;
  logic [ADDR_W-1:0] addressQ;
  logic              accept, subWord, misalign, rdDone;
  logic [31:0]       alignWord, loadData, mergedWord;

  assign accept  = ReqValid && (state == IDLE);
  assign subWord = (ReqSize == SIZE_BYTE) || (ReqSize == SIZE_HALF);
  assign rdDone  = (cntQ == 3'd0);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (ReqSize == SIZE_HALF) ? ReqAddr[0]
                  : ((ReqSize != SIZE_BYTE) && (ReqAddr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misalign)                   stateNext = RESP;
          else if (ReqWrite && !subWord)  stateNext = WR;
          else                            stateNext = RD;
        end
      end
      RD:      if (rdDone) stateNext = reqWriteQ ? MERGE : RESP;
      MERGE:   stateNext = WR;
      WR:      stateNext = RESP;
      RESP:    if (RespReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      reqWriteQ  <= 1'b0;
      signedQ    <= 1'b0;
      sizeQ      <= SIZE_BYTE;
      addrLoQ    <= 2'b00;
      dataQ      <= '0;
      cntQ       <= '0;
      readWordQ  <= '0;
      writeDataQ <= '0;
      respDataQ  <= '0;
      respErrorQ <= 1'b0;
      addressQ   <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (accept) begin
            reqWriteQ  <= ReqWrite;
            signedQ    <= ReqSigned;
            sizeQ      <= ReqSize;
            addrLoQ    <= ReqAddr[1:0];
            dataQ      <= ReqData;
            addressQ   <= {ReqAddr[ADDR_W-1:2], 2'b00};
            cntQ       <= 3'(READ_LATENCY - 1);
            respDataQ  <= '0;
            respErrorQ <= misalign;
            if (ReqWrite && !subWord) writeDataQ <= ReqData;
          end
        end
        RD: begin
          if (rdDone) begin
            if (reqWriteQ) readWordQ <= ReadData;
            else           respDataQ <= loadData;
          end else begin
            cntQ <= cntQ - 3'd1;
          end
        end
        MERGE:   writeDataQ <= mergedWord;
        default: ;
      endcase
    end
  end

  // One aligner serves both directions: live ReadData for loads, the captured word while merging
  assign alignWord = (state == MERGE) ? readWordQ : ReadData;

  lane_align uAlign (
    .word      (alignWord),
    .addrLo    (addrLoQ),
    .size      (sizeQ),
    .isSigned  (signedQ),
    .data      (dataQ),
    .loadData  (loadData),
    .mergedWord(mergedWord)
  );

  assign ReqReady  = (state == IDLE);
  assign RespValid = (state == RESP);
  assign RespData  = respDataQ;
  assign RespError = respErrorQ;
  assign Address   = addressQ;
  assign WriteData = writeDataQ;
  assign MemWrite  = (state == WR) ? MEM_EN : MEM_OFF;
  assign MemRead   = (state == RD) ? MEM_EN : MEM_OFF;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a word-array reference model
module tb_mem_access_unit;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqData;
  logic        RespValid, RespReady, RespError;
  logic [31:0] RespData, Address, WriteData, ReadData;
  logic [1:0]  MemWrite, MemRead;

  logic [31:0] dutMem [0:15];
  logic [31:0] refMem [0:15];

  int checks = 0;
  int errors = 0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  mem_access_unit #(.READ_LATENCY(RL), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData), .RespError(RespError),
    .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  assign ReadData = dutMem[Address[5:2]];
  always @(posedge clk) if (MemWrite == 2'b01) dutMem[Address[5:2]] <= WriteData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] wd, input logic [1:0] sz,
                                          input bit sg, input logic [1:0] lo);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (wd >> (8 * lo)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (wd >> (lo[1] ? 16 : 0)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = wd;
    end
    return v;
  endfunction

  function automatic logic [31:0] refStore(input logic [31:0] wd, input logic [1:0] sz,
                                           input logic [1:0] lo, input logic [31:0] d);
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * lo;
      return (wd & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end else if (sz == 2'd1) begin
      sh = lo[1] ? 16 : 0;
      return (wd & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic resetOutputs(input string tag);
    check({tag, ".ReqReady"}, {31'd0, ReqReady}, 32'd1);
    check({tag, ".RespValid"}, {31'd0, RespValid}, 32'd0);
    check({tag, ".RespData"}, RespData, 32'd0);
    check({tag, ".RespError"}, {31'd0, RespError}, 32'd0);
    check({tag, ".Address"}, Address, 32'd0);
    check({tag, ".WriteData"}, WriteData, 32'd0);
    check({tag, ".MemWrite"}, {30'd0, MemWrite}, 32'd0);
    check({tag, ".MemRead"}, {30'd0, MemRead}, 32'd0);
  endtask

  // One complete request/response; expectations come from refMem and the access rules
  task automatic doReq(input string tag, input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    int lat, reads, writes, expLat, expReads, expWrites;
    bit mis, sub, bothHigh, addrBad;
    logic [31:0] expData, expWData, seenWData;
    sub = (sz < 2'd2);
    mis = TRAP_EN && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00));
    expData = 32'd0; expWData = 32'd0; expReads = 0; expWrites = 0;
    if (mis)            expLat = 1;
    else if (!w) begin  expLat = RL + 1; expReads = RL; expData = refLoad(refMem[a[5:2]], sz, sg, a[1:0]); end
    else if (!sub) begin expLat = 2; expWrites = 1; expWData = d; end
    else begin          expLat = RL + 3; expReads = RL; expWrites = 1; expWData = refStore(refMem[a[5:2]], sz, a[1:0], d); end

    @(negedge clk);
    check({tag, ".ReqReady"}, {31'd0, ReqReady}, 32'd1);
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqData = d;
    lat = 0; reads = 0; writes = 0; bothHigh = 0; addrBad = 0; seenWData = 32'd0;
    while (1) begin
      @(negedge clk);
      ReqValid = 1'b0;
      lat++;
      if (RespValid || lat > 40) break;
      if (MemRead == 2'b01) reads++;
      if (MemWrite == 2'b01) begin writes++; seenWData = WriteData; end
      if (MemRead == 2'b01 && MemWrite == 2'b01) bothHigh = 1;
      if ((MemRead == 2'b01 || MemWrite == 2'b01) && Address !== {a[31:2], 2'b00}) addrBad = 1;
    end
    check({tag, ".latency"}, lat, expLat);
    check({tag, ".RespData"}, RespData, expData);
    check({tag, ".RespError"}, {31'd0, RespError}, {31'd0, mis});
    check({tag, ".readCycles"}, reads, expReads);
    check({tag, ".writeCycles"}, writes, expWrites);
    check({tag, ".exclusive"}, {31'd0, bothHigh}, 32'd0);
    check({tag, ".address"}, {31'd0, addrBad}, 32'd0);
    if (expWrites > 0) check({tag, ".WriteData"}, seenWData, expWData);
    rd = RespData;
    if (expWrites > 0) refMem[a[5:2]] = expWData;
    RespReady = 1'b1;
    @(negedge clk);
    RespReady = 1'b0;
    check({tag, ".RespValidLow"}, {31'd0, RespValid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r, held;
    logic [31:0] wordAt20;
    bit          trapSeen;
    reset = 1'b1; ReqValid = 0; ReqWrite = 0; ReqSize = 0; ReqSigned = 0;
    ReqAddr = 0; ReqData = 0; RespReady = 0;
    for (int i = 0; i < 16; i++) begin
      refMem[i] = $urandom;
      dutMem[i] = refMem[i];
    end
    repeat (2) @(negedge clk);
    resetOutputs("reset");
    reset = 1'b0;

    doReq("wordStore20", 1, 2'd2, 0, 32'd20, 32'h99999999, r);
    doReq("wordLoad20", 0, 2'd2, 0, 32'd20, 32'h0, r);
    check("wordLoad20.value", r, 32'h99999999);

    doReq("wordStore40", 1, 2'd2, 0, 32'd40, 32'h11223344, r);
    doReq("byteStore41", 1, 2'd0, 0, 32'd41, 32'h000000EE, r);
    check("byteStore41.mem", dutMem[10], 32'h1122EE44);
    doReq("sByteLoad41", 0, 2'd0, 1, 32'd41, 32'h0, r);
    check("sByteLoad41.value", r, 32'hFFFFFFEE);
    doReq("uByteLoad41", 0, 2'd0, 0, 32'd41, 32'h0, r);
    check("uByteLoad41.value", r, 32'h000000EE);

    doReq("wordStore40b", 1, 2'd2, 0, 32'd40, 32'h80017FFF, r);
    doReq("sHalfLoad42", 0, 2'd1, 1, 32'd42, 32'h0, r);
    check("sHalfLoad42.value", r, 32'hFFFF8001);
    doReq("sHalfLoad40", 0, 2'd1, 1, 32'd40, 32'h0, r);
    check("sHalfLoad40.value", r, 32'h00007FFF);

    // Response held under backpressure while a new request waits
    @(negedge clk);
    ReqValid = 1; ReqWrite = 0; ReqSize = 2'd2; ReqSigned = 0; ReqAddr = 32'd40;
    @(negedge clk);
    ReqAddr = 32'd20; ReqWrite = 1; ReqData = 32'hDEADBEEF;
    for (int i = 0; i < 20 && !RespValid; i++) @(negedge clk);
    held = RespData;
    check("hold.firstData", held, refMem[10]);
    for (int i = 0; i < 5; i++) begin
      check("hold.RespValid", {31'd0, RespValid}, 32'd1);
      check("hold.RespData", RespData, held);
      check("hold.ReqReady", {31'd0, ReqReady}, 32'd0);
      @(negedge clk);
    end
    ReqValid = 0; RespReady = 1;
    @(negedge clk);
    RespReady = 0;
    check("hold.ignoredStore", dutMem[5], refMem[5]);

    // Reset in RD aborts a sub-word store
    @(negedge clk);
    ReqValid = 1; ReqWrite = 1; ReqSize = 2'd0; ReqAddr = 32'd8; ReqData = 32'h5A;
    @(negedge clk);
    ReqValid = 0;
    check("abort.inRD", {30'd0, MemRead}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    resetOutputs("abort");
    reset = 1'b0;
    repeat (RL + 3) @(negedge clk);
    check("abort.memUnchanged", dutMem[2], refMem[2]);

    // Misaligned word load
    wordAt20 = refMem[5];
    doReq("misWord22", 0, 2'd2, 0, 32'd22, 32'h0, r);
    trapSeen = TRAP_EN;
    check("misWord22.value", r, trapSeen ? 32'd0 : wordAt20);

    for (int i = 0; i < 40; i++) begin
      doReq("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), $urandom, r);
    end
    for (int i = 0; i < 16; i++) check("finalMem", dutMem[i], refMem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
